stress_acc_apb_initiator: RTL and testbench
===========================================

// Module: stress_acc_apb_initiator
// PURPOSE
// - APB-style initiator driving the SVM/KNN accelerator register file
//   (PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PRDATA/PREADY out of the responder).
// - Accepts host commands on a valid/ready stream and buffers them in a small FIFO.
// - Runs each command as an APB setup+access transfer and returns read data or a timeout error.
// - Sits between the host/CPU shim and the accelerator top.
// PARAMETERS
// - FIFO_DEPTH   4    command FIFO entries (power of 2, >=2)
// - TIMEOUT_CYC  16   max ACCESS cycles waiting for PREADY before abort (>=1)
// - AW           32   address width
// - DW           32   data width
// PORTS
// - CLK        in   1   clock, all logic on posedge
// - RESETn     in   1   reset, synchronous, active-low
// - cmd_valid  in   1   host command present
// - cmd_ready  out  1   FIFO not full; transfer when cmd_valid&&cmd_ready
// - cmd_write  in   1   1=write, 0=read
// - cmd_addr   in   AW  register address
// - cmd_wdata  in   DW  write data (ignored for reads)
// - rsp_valid  out  1   response available, held until rsp_ready
// - rsp_ready  in   1   host accepts response
// - rsp_rdata  out  DW  PRDATA captured on a read; 0 for writes and errors
// - rsp_error  out  1   1 = transfer timed out
// - PSEL       out  1   APB select
// - PENABLE    out  1   APB access phase
// - PWRITE     out  1   APB direction
// - PADDR      out  AW  APB address
// - PWDATA     out  DW  APB write data
// - PRDATA     in   DW  responder read data
// - PREADY     in   1   responder ready
// BEHAVIOUR
// - Reset (RESETn low at posedge): FSM=IDLE, FIFO empty, timeout counter=0.
//   All outputs 0 except cmd_ready, which is 1 from the first cycle after reset.
// - Reset mid-transfer: abort immediately. PSEL/PENABLE=0 next cycle, FIFO flushed, no response.
// - FIFO: push on cmd_valid&&cmd_ready; pop only in IDLE->SETUP.
//   cmd_ready = !full, registered count.
//   Push and pop in the same cycle are both legal when not full; count is unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
// - FSM states: IDLE, SETUP, ACCESS, RESP.
//   * IDLE: if FIFO non-empty, pop and go to SETUP. Latch PADDR/PWRITE/PWDATA from the head entry.
//   * SETUP: PSEL=1, PENABLE=0; go to ACCESS unconditionally after 1 cycle.
//   * ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable. Timeout counter increments each cycle.
//     - PREADY=1: capture PRDATA (read only), rsp_error=0, go to RESP.
//     - Otherwise, when counter reaches TIMEOUT_CYC-1 (TIMEOUT_CYC ACCESS cycles without PREADY):
//       rsp_error=1, rsp_rdata=0, go to RESP.
//     - PREADY and timeout in the same cycle: PREADY wins (no error).
//   * RESP: PSEL=PENABLE=0, rsp_valid=1. On rsp_ready go to IDLE and clear the counter.
//     No new APB transfer starts until the response is consumed (strict in-order, one outstanding).
// - Latency: command pushed at edge E0 into an empty FIFO with FSM in IDLE:
//   * SETUP after E1
//   * ACCESS after E2
//   * PREADY sampled high at E3 -> rsp_valid high after E3
//   * minimum 3 cycles command-to-response.
// - Back-to-back: with rsp_ready held high, one transfer every 4 cycles (IDLE, SETUP, ACCESS, RESP).
// - PADDR/PWDATA/PWRITE keep their last values while idle; PWDATA=0 for reads.
// - All outputs are registered; there are no combinational paths from inputs to outputs.
// STRUCTURE
// - Package stress_acc_apb_pkg: typedef enum logic[1:0] apb_init_state_t {IDLE,SETUP,ACCESS,RESP}.
//   Also holds the packed struct apb_cmd_t {write, addr, wdata} and the default parameter constants.
// - Sub-module apb_cmd_fifo (synchronous FIFO of apb_cmd_t, FIFO_DEPTH, full/empty/count).
// - The top holds the FSM, timeout counter and APB output registers.
// TESTING
// - Single write 0x4 <- 0x00000003, PREADY high in first ACCESS cycle:
//   PSEL 2 cycles, PENABLE 1 cycle; rsp_valid after 3 cycles; rsp_error=0, rsp_rdata=0.
// - Read 0x0 with PREADY delayed 3 ACCESS cycles and PRDATA=0x0000_0001:
//   PENABLE high 4 cycles; rsp_rdata=0x1; PADDR stable throughout.
// - PREADY never asserted, TIMEOUT_CYC=16:
//   exactly 16 ACCESS cycles, then rsp_valid with rsp_error=1, rsp_rdata=0.
// - Push 5 commands back-to-back with FIFO_DEPTH=4 and the FSM busy:
//   cmd_ready drops after 4 pushes; all 5 complete in order, addresses 0x0,0x4,0x8,0xC,0x10.
// - Hold rsp_ready=0 for 10 cycles after a response:
//   rsp_valid/rsp_rdata stable, PSEL stays 0, next transfer starts only after rsp_ready.
// - Assert RESETn=0 during ACCESS:
//   next cycle PSEL=PENABLE=rsp_valid=0, FIFO empty; a fresh command afterwards completes normally.

Source files
------------

// File: rtl/stress_acc_apb_initiator_pkg.sv
// Shared types and default constants for the accelerator APB initiator.
package stress_acc_apb_pkg;

  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 16;
  localparam int unsigned DEF_AW          = 32;
  localparam int unsigned DEF_DW          = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_init_state_t;

  typedef struct packed {
    logic              write;
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] wdata;
  } apb_cmd_t;

  // Reads drive an all-zero PWDATA so the bus never carries stale write data.
  function automatic logic [DEF_DW-1:0] apb_wdata_for(input apb_cmd_t c);
    if (c.write) begin
      return c.wdata;
    end else begin
      return '0;
    end
  endfunction

endpackage

// File: rtl/stress_acc_apb_initiator_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap naturally because DEPTH is a power of 2.
module apb_cmd_fifo
  import stress_acc_apb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  apb_cmd_t                 push_data,
  input  logic                     pop,
  output apb_cmd_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  apb_cmd_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_s, pop_s;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next pointer and occupancy values from the qualified push/pop.
  always_comb begin
    push_s   = push && !full;
    pop_s    = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/stress_acc_apb_initiator.sv
// APB initiator: buffers host commands, runs one APB transfer at a time,
// and returns read data or a timeout error strictly in order.
module stress_acc_apb_initiator
  import stress_acc_apb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_error,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY
);

  localparam int unsigned     CW       = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned     FCW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   TO_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic [FCW-1:0]  FULL_CNT = FCW'(FIFO_DEPTH);

  apb_init_state_t state_q, state_d;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_error_q, rsp_error_d;

  apb_cmd_t        cmd_in_s, fifo_head_s;
  logic            fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
  logic [FCW-1:0]  fifo_count_s;

  assign cmd_in_s    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign fifo_push_s = cmd_valid && !fifo_full_s;
  assign cmd_ready   = (fifo_count_s != FULL_CNT);

  apb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (RESETn),
    .push      (fifo_push_s),
    .push_data (cmd_in_s),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Transfer sequencing, timeout counting and response capture.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    fifo_pop_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s = 1'b1;
          state_d    = SETUP;
          paddr_d    = fifo_head_s.addr;
          pwrite_d   = fifo_head_s.write;
          pwdata_d   = apb_wdata_for(fifo_head_s);
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // PREADY is tested first so it wins over a coincident timeout.
        if (PREADY) begin
          state_d     = RESP;
          rsp_error_d = 1'b0;
          if (pwrite_q) begin
            rsp_rdata_d = '0;
          end else begin
            rsp_rdata_d = PRDATA;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d     = RESP;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d  = IDLE;
          to_cnt_d = '0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_stress_acc_apb_initiator.sv
// Randomized bench for the APB initiator: random host traffic, random
// responder wait states and response back-pressure, occasional resets.
module tb_stress_acc_apb_initiator;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic        CLK, RESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [31:0] PADDR, PWDATA, PRDATA;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          push_cyc;
  } cmd_t;

  cmd_t        q[$];
  cmd_t        cur;
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_free = 0;
  int          setup_cyc = 0;
  int          acc_cnt = 0;
  int          cur_delay = 0;
  int          exp_acc = 0;
  int          hold = 0;
  int          n_done = 0;
  int          n_resets = 0;
  logic [31:0] cur_prdata = 32'h0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err = 1'b0;
  bit          have_inflight = 1'b0;
  bit          rsp_seen = 1'b0;

  stress_acc_apb_initiator #(
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .AW(32), .DW(32)
  ) dut (
    .CLK(CLK), .RESETn(RESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Wait states before PREADY: mostly short, some around the timeout edge, some beyond it.
  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
    else if (r < 8) return int'($urandom_range(TMO - 2, TMO));
    else return int'($urandom_range(TMO + 1, TMO + 6));
  endfunction

  task automatic step_cycle(input bit drain, input bit allow_reset);
    cmd_t c;
    @(negedge CLK);
    cyc++;

    // setup phase: the next queued command must appear on the bus
    if (PSEL && !PENABLE) begin
      check_eq("one_outstanding", 64'(have_inflight), 64'(0));
      check_eq("setup_has_cmd", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) begin
        cur = q.pop_front();
        check_eq("setup_cycle", 64'(cyc), 64'(max2(last_free, cur.push_cyc) + 2));
        check_eq("setup_paddr", 64'(PADDR), 64'(cur.addr));
        check_eq("setup_pwrite", 64'(PWRITE), 64'(cur.write));
        check_eq("setup_pwdata", 64'(PWDATA), 64'(cur.write ? cur.wdata : 32'h0));
        have_inflight = 1'b1;
        rsp_seen      = 1'b0;
        setup_cyc     = cyc;
        acc_cnt       = 0;
        cur_delay     = pick_delay();
        cur_prdata    = $urandom;
      end
    end

    // access phase: responder answers after cur_delay wait states
    if (PSEL && PENABLE) begin
      check_eq("access_has_xfer", 64'(have_inflight), 64'(1));
    end
    if (PSEL && PENABLE && have_inflight) begin
      acc_cnt++;
      check_eq("access_bound", 64'(acc_cnt <= int'(TMO)), 64'(1));
      check_eq("access_paddr", 64'(PADDR), 64'(cur.addr));
      check_eq("access_pwrite", 64'(PWRITE), 64'(cur.write));
      check_eq("access_pwdata", 64'(PWDATA), 64'(cur.write ? cur.wdata : 32'h0));
      PREADY = (acc_cnt == cur_delay + 1);
      PRDATA = PREADY ? cur_prdata : $urandom;
    end else begin
      PREADY = 1'($urandom_range(0, 1));
      PRDATA = $urandom;
    end

    // response: outcome follows from the wait states chosen for this transfer
    if (rsp_valid) begin
      check_eq("rsp_has_xfer", 64'(have_inflight), 64'(1));
      check_eq("psel_in_resp", 64'(PSEL), 64'(0));
      if (have_inflight) begin
        if (!rsp_seen) begin
          exp_err   = (cur_delay >= int'(TMO));
          exp_acc   = exp_err ? int'(TMO) : cur_delay + 1;
          exp_rdata = (exp_err || cur.write) ? 32'h0 : cur_prdata;
          check_eq("access_cycles", 64'(acc_cnt), 64'(exp_acc));
          check_eq("rsp_latency", 64'(cyc), 64'(setup_cyc + 1 + exp_acc));
          rsp_seen = 1'b1;
        end
        check_eq("rsp_error", 64'(rsp_error), 64'(exp_err));
        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      end
    end

    check_eq("cmd_ready", 64'(cmd_ready), 64'(q.size() < int'(DEPTH)));

    if (allow_reset && PSEL && PENABLE && n_resets < 4 && $urandom_range(0, 19) == 0) begin
      n_resets++;
      RESETn    = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      PREADY    = 1'b0;
      @(negedge CLK);
      cyc++;
      check_eq("rst_psel", 64'(PSEL), 64'(0));
      check_eq("rst_penable", 64'(PENABLE), 64'(0));
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      RESETn = 1'b1;
      q.delete();
      have_inflight = 1'b0;
      rsp_seen      = 1'b0;
      last_free     = cyc;
      hold          = 0;
    end else begin
      // response back-pressure, including long holds
      if (drain) begin
        rsp_ready = 1'b1;
      end else if (hold > 0) begin
        rsp_ready = 1'b0;
        hold--;
      end else begin
        if ($urandom_range(0, 19) == 0) hold = 10;
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (rsp_valid && rsp_ready && have_inflight && rsp_seen) begin
        have_inflight = 1'b0;
        last_free     = cyc;
        n_done++;
      end
      // host commands
      cmd_valid = !drain && ($urandom_range(0, 9) < 7);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 32'($urandom_range(0, 255)) << 2;
      cmd_wdata = $urandom;
      if (cmd_valid && cmd_ready) begin
        c.write    = cmd_write;
        c.addr     = cmd_addr;
        c.wdata    = cmd_wdata;
        c.push_cyc = cyc;
        q.push_back(c);
      end
    end
  endtask

  initial begin
    RESETn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PRDATA    = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_eq("reset_psel", 64'(PSEL), 64'(0));
    check_eq("reset_penable", 64'(PENABLE), 64'(0));
    check_eq("reset_pwrite", 64'(PWRITE), 64'(0));
    check_eq("reset_paddr", 64'(PADDR), 64'(0));
    check_eq("reset_pwdata", 64'(PWDATA), 64'(0));
    check_eq("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check_eq("reset_rsp_error", 64'(rsp_error), 64'(0));
    check_eq("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    RESETn    = 1'b1;
    last_free = cyc;

    for (int i = 0; i < 4000; i++) begin
      step_cycle(1'b0, 1'b1);
    end
    for (int k = 0; k < 800 && (q.size() != 0 || have_inflight); k++) begin
      step_cycle(1'b1, 1'b0);
    end
    check_eq("drain_complete", 64'(q.size() == 0 && !have_inflight), 64'(1));
    check_eq("progress", 64'(n_done > 100), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
